// File: rtl/point_pkg.sv
// Shared sizes and state encoding for the point streamer.
// Optional distance datapath is enabled with POINT_DIST_EN.
package point_pkg;

  localparam int N_POINTS = 64;
  localparam int COORD_W  = 8;
  localparam int IDX_W    = $clog2(N_POINTS);
  localparam int DIST_W   = 2*COORD_W+1;
  localparam int TOT_W    = DIST_W+IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } ps_state_t;

endpackage

// File: rtl/point_stream_sq_dist.sv
// Combinational squared Euclidean distance between two points.
// Used by point_stream only when POINT_DIST_EN is defined.
module sq_dist
  import point_pkg::*;
#(
  parameter int CW = point_pkg::COORD_W
) (
  input  logic [CW-1:0] ax,
  input  logic [CW-1:0] ay,
  input  logic [CW-1:0] bx,
  input  logic [CW-1:0] by,
  output logic [2*CW:0] d
);

  logic [CW-1:0]   dx;
  logic [CW-1:0]   dy;
  logic [2*CW-1:0] wx;
  logic [2*CW-1:0] wy;
  logic [2*CW-1:0] sx;
  logic [2*CW-1:0] sy;

  always_comb begin
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
    wx = {{CW{1'b0}}, dx};
    wy = {{CW{1'b0}}, dy};
    sx = wx * wx;
    sy = wy * wy;
    d  = {1'b0, sx} + {1'b0, sy};
  end

endmodule

// File: rtl/point_stream.sv
// Streams the initializer's point arrays out over valid/ready.
// Define POINT_DIST_EN for per-point and closed-tour distances.
module point_stream #(
  parameter int N_POINTS = point_pkg::N_POINTS,
  parameter int COORD_W  = point_pkg::COORD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 xs [N_POINTS],
  input  logic [31:0]                 ys [N_POINTS],
  input  logic                        complete,
  input  logic                        restart,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_POINTS)-1:0] out_idx,
  output logic [COORD_W-1:0]          out_x,
  output logic [COORD_W-1:0]          out_y,
  output logic                        out_last,
  output logic                        done
`ifdef POINT_DIST_EN
  ,
  output logic [2*COORD_W:0]          out_dist,
  output logic [2*COORD_W+$clog2(N_POINTS):0] total_dist
`endif
);

  import point_pkg::*;

  localparam int IW = $clog2(N_POINTS);

  ps_state_t         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic              ld;
  logic [IW-1:0]     ld_idx;
  logic [COORD_W-1:0] ld_x;
  logic [COORD_W-1:0] ld_y;
  logic              hs;
  logic              unused_hi;

  assign hs   = valid_q && out_ready;
  assign ld_x = xs[ld_idx][COORD_W-1:0];
  assign ld_y = ys[ld_idx][COORD_W-1:0];

  always_comb begin
    unused_hi = 1'b0;
    for (int i = 0; i < N_POINTS; i++) begin
      unused_hi ^= ^{xs[i][31:COORD_W],
                     ys[i][31:COORD_W]};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    last_d  = last_q;
    done_d  = done_q;
    ld      = 1'b0;
    ld_idx  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (complete) begin
          ld      = 1'b1;
          ld_idx  = '0;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (idx_q == IW'(N_POINTS-1)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            ld     = 1'b1;
            ld_idx = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        if (restart) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      idx_d  = ld_idx;
      x_d    = ld_x;
      y_d    = ld_y;
      last_d = (ld_idx == IW'(N_POINTS-1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_last  = last_q;
  assign done      = done_q;

`ifdef POINT_DIST_EN
  localparam int DW = 2*COORD_W+1;
  localparam int TW = DW+IW;

  logic [IW-1:0]      pv_idx;
  logic [COORD_W-1:0] pv_x;
  logic [COORD_W-1:0] pv_y;
  logic [DW-1:0]      ld_dist;
  logic [DW-1:0]      dist_q, dist_d;
  logic [TW-1:0]      tot_q, tot_d;
  logic               tot_clr;
  logic               tot_acc;

  // Index wraps so point 0 pairs with the last point, closing the tour.
  assign pv_idx = ld_idx - IW'(1);
  assign pv_x   = xs[pv_idx][COORD_W-1:0];
  assign pv_y   = ys[pv_idx][COORD_W-1:0];

  sq_dist #(
    .CW(COORD_W)
  ) u_sq (
    .ax(ld_x),
    .ay(ld_y),
    .bx(pv_x),
    .by(pv_y),
    .d (ld_dist)
  );

  assign tot_clr = (state_q == IDLE) && complete;
  assign tot_acc = (state_q == SEND) && hs;

  always_comb begin
    dist_d = ld ? ld_dist : dist_q;
    tot_d  = tot_q;
    if (tot_clr) begin
      tot_d = '0;
    end else if (tot_acc) begin
      tot_d = tot_q + TW'(dist_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dist_q <= '0;
      tot_q  <= '0;
    end else begin
      dist_q <= dist_d;
      tot_q  <= tot_d;
    end
  end

  assign out_dist   = dist_q;
  assign total_dist = tot_q;
`endif

endmodule
